// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch/data request ports and memory command bus of the arbiter
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ready, if_rdata, d_ready, d_rdata, mem_valid, mem_we, mem_addr, mem_wdata, busy
  );
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ready, if_rdata, d_ready, d_rdata, mem_valid, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory between fetch and data, data first with fetch starvation guard
module mem_port_arbiter #(
  parameter int MEM_LATENCY  = 4,
  parameter int STARVE_LIMIT = 3
) (
  input logic clk,
  input logic reset,
  mem_port_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3;
  localparam logic [3:0] LAT = 4'(MEM_LATENCY), LIM = 4'(STARVE_LIMIT);
  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d, starve_q, starve_d;
  logic        grant_d_q, grant_d_d;
  logic        if_ready_q, if_ready_d, d_ready_q, d_ready_d;
  logic [31:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic        mem_valid_q, mem_valid_d, mem_we_q, mem_we_d, busy_q, busy_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic        grant, win_d, last;
  always_comb begin
    grant       = state_q == IDLE && (bus.if_req || bus.d_req);
    win_d       = bus.d_req && !(bus.if_req && starve_q == LIM);
    last        = state_q == WAIT && cnt_q == 4'd1;
    state_d     = state_q == IDLE  ? (grant ? ISSUE : IDLE) :
                  state_q == ISSUE ? WAIT :
                  state_q == WAIT  ? (last ? DONE : WAIT) : IDLE;
    cnt_d       = state_q == ISSUE ? LAT : state_q == WAIT ? cnt_q - 4'd1 : cnt_q;
    grant_d_d   = grant ? win_d : grant_d_q;
    starve_d    = !grant ? starve_q :
                  !win_d ? 4'd0 :
                  (bus.if_req && starve_q < LIM) ? starve_q + 4'd1 : starve_q;
    mem_valid_d = grant;
    mem_we_d    = grant ? win_d && bus.d_we : mem_we_q;
    mem_addr_d  = grant ? (win_d ? bus.d_addr : bus.if_addr) : mem_addr_q;
    mem_wdata_d = grant && win_d ? bus.d_wdata : mem_wdata_q;
    if_rdata_d  = last && !mem_we_q && !grant_d_q ? bus.mem_rdata : if_rdata_q;
    d_rdata_d   = last && !mem_we_q && grant_d_q ? bus.mem_rdata : d_rdata_q;
    if_ready_d  = last && !grant_d_q;
    d_ready_d   = last && grant_d_q;
    busy_d      = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      starve_q    <= 4'd0;
      grant_d_q   <= 1'b0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
      if_rdata_q  <= 32'd0;
      d_rdata_q   <= 32'd0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      grant_d_q   <= grant_d_d;
      if_ready_q  <= if_ready_d;
      d_ready_q   <= d_ready_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end
  assign bus.if_ready  = if_ready_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_ready   = d_ready_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: transaction-level model check of the arbiter plus directed timing pins
module tb_mem_port_arbiter;
  localparam int L = 4, S = 3;
  logic clk = 1'b0, reset = 1'b1, reset1 = 1'b1;
  always #5 clk = ~clk;
  mem_port_arbiter_if bus ();
  mem_port_arbiter_if bus1 ();
  mem_port_arbiter #(.MEM_LATENCY(L), .STARVE_LIMIT(S)) u_dut (.clk(clk), .reset(reset), .bus(bus));
  mem_port_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(1)) u_dut1 (.clk(clk), .reset(reset1), .bus(bus1));
  int n_chk = 0, n_fail = 0, cyc = 0;
  bit done1 = 0;
  bit m_act, m_gd, m_we;
  int m_k, m_starve;
  logic [31:0] m_addr, m_wdata, e_if_rdata, e_d_rdata, e_mem_addr;
  logic e_mem_we;
  int qv[$], qr_t[$];
  bit qr_d[$], qw[$];
  logic [31:0] qa[$], qwd[$];
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a == 32'h40 ? 32'hDEADBEEF : (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction
  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic model_advance();
    if (reset) begin
      m_act = 0; m_k = 0; m_gd = 0; m_we = 0; m_starve = 0;
      e_if_rdata = 0; e_d_rdata = 0; e_mem_addr = 0; e_mem_we = 0;
    end else if (m_act) begin
      if (m_k == L + 1 && !m_we) begin
        if (m_gd) e_d_rdata = mem_word(m_addr);
        else e_if_rdata = mem_word(m_addr);
      end
      if (m_k == L + 2) m_act = 0;
      else m_k++;
    end else if (bus.if_req || bus.d_req) begin
      m_gd = bus.d_req && !(bus.if_req && m_starve == S);
      if (!m_gd) m_starve = 0;
      else if (bus.if_req && m_starve < S) m_starve++;
      m_we = m_gd && bus.d_we;
      m_addr = m_gd ? bus.d_addr : bus.if_addr;
      m_wdata = bus.d_wdata;
      m_act = 1; m_k = 1;
      e_mem_addr = m_addr; e_mem_we = m_we;
    end
  endtask
  task automatic compare();
    bit ev, eir, edr;
    ev  = m_act && m_k == 1;
    eir = m_act && m_k == L + 2 && !m_gd;
    edr = m_act && m_k == L + 2 && m_gd;
    chk1("busy", bus.busy, m_act);
    chk1("mem_valid", bus.mem_valid, ev);
    chk1("if_ready", bus.if_ready, eir);
    chk1("d_ready", bus.d_ready, edr);
    chk32("if_rdata", bus.if_rdata, e_if_rdata);
    chk32("d_rdata", bus.d_rdata, e_d_rdata);
    chk32("mem_addr", bus.mem_addr, e_mem_addr);
    chk1("mem_we", bus.mem_we, e_mem_we);
    if (ev && m_we) chk32("mem_wdata", bus.mem_wdata, m_wdata);
  endtask
  task automatic step();
    bus.mem_rdata = (m_act && m_k == L + 1) ? mem_word(m_addr) : $urandom();
    model_advance();
    @(negedge clk);
    cyc++;
    compare();
  endtask
  task automatic run(input int n, input bit hold);
    qv.delete(); qr_t.delete(); qr_d.delete(); qa.delete(); qw.delete(); qwd.delete();
    for (int t = 1; t <= n; t++) begin
      step();
      if (bus.mem_valid) begin
        qv.push_back(t); qa.push_back(bus.mem_addr); qw.push_back(bus.mem_we); qwd.push_back(bus.mem_wdata);
      end
      if (bus.if_ready) begin
        qr_t.push_back(t); qr_d.push_back(1'b0);
        if (!hold) bus.if_req = 0;
      end
      if (bus.d_ready) begin
        qr_t.push_back(t); qr_d.push_back(1'b1);
        if (!hold) bus.d_req = 0;
      end
    end
  endtask
  initial begin
    logic [7:0] pat;
    bit if_pend, d_pend, rst_prev, eir, edr, srv_i, srv_d;
    bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
    reset = 1;
    step(); step();
    reset = 0;
    bus.if_req = 1; bus.if_addr = 32'h40;
    run(12, 0);
    chk32("t1_nvalid", qv.size(), 1);
    chk32("t1_valid_cyc", qv.size() > 0 ? qv[0] : -1, 1);
    chk32("t1_addr", qa.size() > 0 ? qa[0] : 32'hX, 32'h40);
    chk1("t1_we", qw.size() > 0 ? qw[0] : 1'b1, 1'b0);
    chk32("t1_nready", qr_t.size(), 1);
    chk32("t1_ready_cyc", qr_t.size() > 0 ? qr_t[0] : -1, 6);
    chk32("t1_rdata", bus.if_rdata, 32'hDEADBEEF);
    bus.if_req = 1; bus.if_addr = 32'h80; bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h100;
    run(16, 0);
    chk32("t2_nready", qr_t.size(), 2);
    chk32("t2_d_cyc", qr_t.size() > 0 ? qr_t[0] : -1, 6);
    chk1("t2_d_first", qr_d.size() > 0 ? qr_d[0] : 1'b0, 1'b1);
    chk32("t2_if_issue", qv.size() > 1 ? qv[1] : -1, 8);
    chk32("t2_if_cyc", qr_t.size() > 1 ? qr_t[1] : -1, 13);
    chk32("t2_d_rdata", bus.d_rdata, mem_word(32'h100));
    chk32("t2_if_rdata", bus.if_rdata, mem_word(32'h80));
    bus.if_req = 1; bus.d_req = 1;
    run(56, 1);
    bus.if_req = 0; bus.d_req = 0;
    pat = 0;
    for (int i = 0; i < 8 && i < qr_d.size(); i++) pat = {pat[6:0], qr_d[i]};
    chk32("t3_nready", qr_t.size(), 8);
    chk32("t3_order", {24'd0, pat}, 32'hEE);
    chk32("t3_gap", qr_t.size() > 1 ? qr_t[1] - qr_t[0] : -1, 7);
    run(8, 0);
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h200; bus.d_wdata = 32'h12345678;
    run(10, 0);
    bus.d_we = 0;
    chk32("t4_nvalid", qv.size(), 1);
    chk1("t4_we", qw.size() > 0 ? qw[0] : 1'b0, 1'b1);
    chk32("t4_addr", qa.size() > 0 ? qa[0] : 32'hX, 32'h200);
    chk32("t4_wdata", qwd.size() > 0 ? qwd[0] : 32'hX, 32'h12345678);
    chk32("t4_ready_cyc", qr_t.size() > 0 ? qr_t[0] : -1, 6);
    chk32("t4_d_rdata_kept", bus.d_rdata, mem_word(32'h100));
    bus.if_req = 1; bus.if_addr = 32'h300;
    run(3, 1);
    reset = 1;
    step();
    chk1("t5_busy", bus.busy, 1'b0);
    chk1("t5_valid", bus.mem_valid, 1'b0);
    chk32("t5_addr", bus.mem_addr, 32'h0);
    chk32("t5_if_rdata", bus.if_rdata, 32'h0);
    chk32("t5_d_rdata", bus.d_rdata, 32'h0);
    reset = 0; bus.if_req = 0;
    run(10, 0);
    chk32("t5_no_ready", qr_t.size(), 0);
    bus.if_req = 1; bus.if_addr = 32'h40;
    run(10, 0);
    chk32("t5_ready_cyc", qr_t.size() > 0 ? qr_t[0] : -1, 6);
    chk32("t5_rdata", bus.if_rdata, 32'hDEADBEEF);
    if_pend = 0; d_pend = 0; rst_prev = 0;
    for (int i = 0; i < 3000; i++) begin
      eir = m_act && m_k == L + 2 && !m_gd;
      edr = m_act && m_k == L + 2 && m_gd;
      if (eir || rst_prev) if_pend = 0;
      if (edr || rst_prev) d_pend = 0;
      srv_i = m_act && !m_gd && !eir;
      srv_d = m_act && m_gd && !edr;
      if (if_pend && srv_i && $urandom_range(0, 15) == 0) if_pend = 0;
      if (d_pend && srv_d && $urandom_range(0, 15) == 0) d_pend = 0;
      if (!if_pend && !srv_i && $urandom_range(0, 2) == 0) begin
        if_pend = 1; bus.if_addr = $urandom() & 32'hFFFF_FFFC;
      end
      if (!d_pend && !srv_d && $urandom_range(0, 1) == 0) begin
        d_pend = 1; bus.d_we = $urandom_range(0, 1) == 1;
        bus.d_addr = $urandom() & 32'hFFFF_FFFC; bus.d_wdata = $urandom();
      end
      bus.if_req = if_pend; bus.d_req = d_pend;
      reset = $urandom_range(0, 127) == 0;
      rst_prev = reset;
      step();
    end
    reset = 0;
    for (int i = 0; i < 1000 && !done1; i++) @(negedge clk);
    chk1("l1_done", done1, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    bit prev_mv;
    int last_r, nr;
    bus1.if_req = 0; bus1.if_addr = 32'h10; bus1.d_req = 0; bus1.d_we = 0;
    bus1.d_addr = 0; bus1.d_wdata = 0; bus1.mem_rdata = 32'h55;
    reset1 = 1;
    repeat (3) @(negedge clk);
    reset1 = 0; bus1.if_req = 1;
    prev_mv = 0; last_r = -1; nr = 0;
    for (int t = 1; t <= 40; t++) begin
      @(negedge clk);
      chk1("l1_mv_consec", bus1.mem_valid && prev_mv, 1'b0);
      prev_mv = bus1.mem_valid;
      if (bus1.if_ready) begin
        chk32("l1_period", last_r < 0 ? t : t - last_r, last_r < 0 ? 3 : 4);
        last_r = t; nr++;
      end
    end
    chk32("l1_nready", nr, 10);
    chk32("l1_rdata", bus1.if_rdata, 32'h55);
    done1 = 1;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates one single-ported, fixed-latency unified memory between the pipelined CPU's instruction-fetch stage (IF) and data-memory stage (MEM). Each requester holds a level request until it receives a one-cycle ready pulse. The arbiter owns the memory command bus and sequences every access through a small FSM. Data accesses have priority, and a starvation counter guarantees forward progress for fetch.

## Interface
- MEM_LATENCY, 4, cycles from the memory command cycle (mem_valid=1) to the cycle mem_rdata is valid; legal range 1..15
- STARVE_LIMIT, 3, consecutive data grants, taken while fetch was waiting, after which fetch wins the next tie; legal range 1..15
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request; held with if_addr stable until if_ready
- if_addr  in  32  fetch byte address
- if_ready  out  1  one-cycle completion pulse for fetch
- if_rdata  out  32  fetched word; valid when if_ready=1, held until next fetch completes
- d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_ready
- d_we  in  1  1 = write, 0 = read
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_ready  out  1  one-cycle completion pulse for data (reads and writes)
- d_rdata  out  32  load data; valid when d_ready=1 after a read, held until next data read completes
- mem_valid  out  1  memory command strobe, high for exactly one cycle per access
- mem_we  out  1  memory write enable, qualified by mem_valid
- mem_addr  out  32  memory address, held from ISSUE until next ISSUE
- mem_wdata  out  32  memory write data, held like mem_addr
- mem_rdata  in  32  memory read data, valid MEM_LATENCY cycles after mem_valid
- busy  out  1  high whenever state != IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE; all outputs registered.
- IDLE: no request -> stay. Any request -> latch the winner (grant_d flag, we, addr, wdata; fetch forces we=0) and go to ISSUE.
- Winner selection:
  - Only one request -> that requester wins.
  - Both requesting -> data wins, unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
- starve_cnt (4-bit):
  - +1 on a data grant while if_req=1, saturating at STARVE_LIMIT.
  - Cleared on a fetch grant.
  - Unchanged on a data grant while if_req=0.
- ISSUE: mem_valid=1 with the latched command. Load wait counter with MEM_LATENCY, go to WAIT.
- WAIT: decrement the counter each cycle. At counter==1:
  - For a read, capture mem_rdata into if_rdata or d_rdata per grant_d.
  - Go to DONE.
- DONE: pulse if_ready or d_ready per grant_d, go to IDLE. Requests are not sampled in DONE, so the served requester's still-high req is not re-granted.
- Writes follow the same path. d_rdata is unchanged on writes.
- Request deasserted mid-transaction: the access still completes and ready still pulses.
- Reset values: state IDLE; if_ready 0, d_ready 0, if_rdata 0, d_rdata 0, mem_valid 0, mem_we 0, mem_addr 0, mem_wdata 0, busy 0, starve_cnt 0, grant_d 0.

## Timing
- Request sampled high in IDLE at cycle 0 -> ISSUE in cycle 1 (mem_valid=1) -> WAIT in cycles 2..1+MEM_LATENCY -> rdata captured at end of cycle 1+MEM_LATENCY -> ready=1 in cycle 2+MEM_LATENCY.
- Request-to-ready latency is MEM_LATENCY+2 cycles.
- Peak throughput is one access per MEM_LATENCY+3 cycles: DONE is followed by IDLE before the next grant.
- The loser of arbitration is granted in the IDLE cycle directly after the winner's DONE, if still requesting.
- ready and mem_valid are never high for more than one consecutive cycle. if_ready and d_ready are never high together.
- Reset asserted in any state:
  - All outputs take reset values on the next edge.
  - An in-flight memory response is discarded, and no ready pulse is emitted for it.
  - Requesters re-request after reset drops.

## Test plan
- Single fetch, MEM_LATENCY=4, if_addr=0x40, memory returns 0xDEADBEEF -> mem_valid only in cycle 1 with addr 0x40 and we=0; if_ready=1 only in cycle 6; if_rdata=0xDEADBEEF.
- if_req and d_req rise in the same cycle, data read of 0x100 -> data served first (d_ready in cycle 6), then fetch issued in cycle 8 and if_ready in cycle 13.
- Starvation, STARVE_LIMIT=3, d_req and if_req held high continuously -> grant order D,D,D,F,D,D,D,F; starve_cnt never exceeds 3.
- Data write, d_addr=0x200, d_wdata=0x12345678 -> mem_valid=1 with mem_we=1 and the latched address/data for one cycle; d_ready pulses; d_rdata keeps its previous value.
- Reset asserted in WAIT -> next cycle state IDLE with all outputs 0; no ready pulse for the aborted access; a fetch requested after reset completes normally.
- MEM_LATENCY=1 back-to-back fetches with if_req held -> if_ready pulses every 4 cycles; mem_valid is never high in two consecutive cycles.
